// File: rtl/pc_stack_unit_if.sv
// Decoder-side bundle for pc_stack_unit: command strobes and targets in,
// fetch address and stack status out.
interface pc_stack_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned OFF_WIDTH   = 8,
    parameter int unsigned STACK_DEPTH = 8
);
    localparam int unsigned SP_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic                  clk_valid;
    logic                  pc_inc;
    logic                  pc_load;
    logic                  pc_rel;
    logic                  call;
    logic                  ret;
    logic                  err_clr;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [OFF_WIDTH-1:0]  rel_offset;

    logic [ADDR_WIDTH-1:0] pc_out;
    logic                  bootstrapping;
    logic                  stack_empty;
    logic                  stack_full;
    logic                  stack_ovf;
    logic                  stack_unf;
    logic [SP_WIDTH-1:0]   sp_out;

    modport master (
        output clk_valid, pc_inc, pc_load, pc_rel, call, ret, err_clr, pc_next, rel_offset,
        input  pc_out, bootstrapping, stack_empty, stack_full, stack_ovf, stack_unf, sp_out
    );

    modport slave (
        input  clk_valid, pc_inc, pc_load, pc_rel, call, ret, err_clr, pc_next, rel_offset,
        output pc_out, bootstrapping, stack_empty, stack_full, stack_ovf, stack_unf, sp_out
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with return-address stack, relative jumps and sticky stack errors.
// Define PC_STACK_WRAP_EN to make the stack circular (call when full overwrites the oldest entry).
module pc_stack_unit #(
    parameter int unsigned           ADDR_WIDTH   = 12,
    parameter int unsigned           OFF_WIDTH    = 8,
    parameter int unsigned           STACK_DEPTH  = 8,
    parameter int unsigned           BOOT_LIMIT   = 'h200,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic            clk,
    input logic            arst_n,
    pc_stack_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned SP_W  = PTR_W + 1;

    logic [ADDR_WIDTH-1:0]        pc_q, pc_d, pc_plus1;
    logic [SP_W-1:0]              sp_q, sp_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d, top_idx;
    logic                         ovf_q, ovf_d, unf_q, unf_d;
    logic                         push_en, full, empty;
    logic signed [OFF_WIDTH-1:0]  off_s;
    logic signed [ADDR_WIDTH-1:0] off_ext;
    logic [ADDR_WIDTH-1:0]        stack_mem [STACK_DEPTH];

    assign pc_plus1 = pc_q + ADDR_WIDTH'(1);
    assign off_s    = bus.rel_offset;
    assign off_ext  = ADDR_WIDTH'(off_s);
    // ptr_q is the next write slot; when full in circular mode it also marks the oldest entry
    assign top_idx  = ptr_q - PTR_W'(1);
    assign full     = (sp_q == SP_W'(STACK_DEPTH));
    assign empty    = (sp_q == '0);

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (bus.clk_valid) begin
            // Clear first so an error raised below in the same cycle wins.
            if (bus.err_clr) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
            if (bus.pc_load) begin
                pc_d = bus.pc_next;
            end else if (bus.call) begin
                pc_d = bus.pc_next;
                if (!full) begin
                    push_en = 1'b1;
                    ptr_d   = ptr_q + PTR_W'(1);
                    sp_d    = sp_q + SP_W'(1);
                end else begin
                    ovf_d = 1'b1;
`ifdef PC_STACK_WRAP_EN
                    push_en = 1'b1;
                    ptr_d   = ptr_q + PTR_W'(1);
`else
                    push_en = 1'b0;
`endif
                end
            end else if (bus.ret) begin
                if (!empty) begin
                    pc_d  = stack_mem[top_idx];
                    ptr_d = top_idx;
                    sp_d  = sp_q - SP_W'(1);
                end else begin
                    pc_d  = pc_plus1;
                    unf_d = 1'b1;
                end
            end else if (bus.pc_rel) begin
                pc_d = pc_q + ADDR_WIDTH'(off_ext);
            end else if (bus.pc_inc) begin
                pc_d = pc_plus1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q  <= RESET_VECTOR;
            sp_q  <= '0;
            ptr_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // NOTE: stack storage has no reset; entries are only read when sp_q says they were written.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[ptr_q] <= pc_plus1;
        end
    end

    assign bus.pc_out        = pc_q;
    assign bus.bootstrapping = (32'(pc_q) < BOOT_LIMIT);
    assign bus.stack_empty   = empty;
    assign bus.stack_full    = full;
    assign bus.stack_ovf     = ovf_q;
    assign bus.stack_unf     = unf_q;
    assign bus.sp_out        = sp_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed scenarios then randomized commands
// against a queue-based reference model.
module tb_pc_stack_unit;
    localparam int AW = 12;
    localparam int OW = 8;
    localparam int D  = 8;
    localparam int BOOT = 'h200;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    pc_stack_unit_if #(.ADDR_WIDTH(AW), .OFF_WIDTH(OW), .STACK_DEPTH(D)) bus ();

    pc_stack_unit #(
        .ADDR_WIDTH(AW), .OFF_WIDTH(OW), .STACK_DEPTH(D), .BOOT_LIMIT(BOOT), .RESET_VECTOR('0)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: PC value, return stack as a queue (back = top), sticky flags.
    logic [AW-1:0] pc_m;
    logic [AW-1:0] stk_m [$];
    logic          ovf_m, unf_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"},    32'(bus.pc_out), 32'(pc_m));
        chk({tag, ".sp"},    32'(bus.sp_out), 32'(stk_m.size()));
        chk({tag, ".empty"}, 32'(bus.stack_empty), 32'(stk_m.size() == 0));
        chk({tag, ".full"},  32'(bus.stack_full), 32'(stk_m.size() == D));
        chk({tag, ".ovf"},   32'(bus.stack_ovf), 32'(ovf_m));
        chk({tag, ".unf"},   32'(bus.stack_unf), 32'(unf_m));
        chk({tag, ".boot"},  32'(bus.bootstrapping), 32'(int'(pc_m) < BOOT));
    endtask

    task automatic model_reset();
        pc_m = '0;
        stk_m.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic model_step();
        logic new_ovf, new_unf;
        logic [AW-1:0] dummy;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (!bus.clk_valid) return;
        if (bus.pc_load) begin
            pc_m = bus.pc_next;
        end else if (bus.call) begin
            if (stk_m.size() < D) begin
                stk_m.push_back(pc_m + AW'(1));
            end else begin
                new_ovf = 1'b1;
`ifdef PC_STACK_WRAP_EN
                dummy = stk_m.pop_front();
                stk_m.push_back(pc_m + AW'(1));
`endif
            end
            pc_m = bus.pc_next;
        end else if (bus.ret) begin
            if (stk_m.size() > 0) begin
                pc_m = stk_m.pop_back();
            end else begin
                pc_m    = pc_m + AW'(1);
                new_unf = 1'b1;
            end
        end else if (bus.pc_rel) begin
            pc_m = AW'(int'(pc_m) + int'($signed(bus.rel_offset)));
        end else if (bus.pc_inc) begin
            pc_m = pc_m + AW'(1);
        end
        if (bus.err_clr) begin
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end
        ovf_m = ovf_m | new_ovf;
        unf_m = unf_m | new_unf;
    endtask

    task automatic idle_inputs();
        bus.clk_valid  = 1'b1;
        bus.pc_inc     = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_rel     = 1'b0;
        bus.call       = 1'b0;
        bus.ret        = 1'b0;
        bus.err_clr    = 1'b0;
        bus.pc_next    = '0;
        bus.rel_offset = '0;
    endtask

    // Inputs are already driven; advance one edge, update the model, sample 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_state(tag);
        idle_inputs();
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 arst_n = 1'b0;
        #1;
        model_reset();
        check_state(tag);
        @(negedge clk) arst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #3;
        check_state("reset");
        @(negedge clk) arst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            bus.pc_inc = 1'b1;
            step("inc");
        end
        chk("inc3.pc", 32'(bus.pc_out), 32'h3);

        bus.pc_load = 1'b1; bus.pc_next = 'h1FF; step("load_1ff");
        bus.pc_inc = 1'b1; step("inc_boot_edge");
        chk("boot_edge.pc", 32'(bus.pc_out), 32'h200);
        chk("boot_edge.boot", 32'(bus.bootstrapping), 32'h0);

        bus.pc_load = 1'b1; bus.pc_next = 'h010; step("load_010");
        bus.call = 1'b1; bus.pc_next = 'h300; step("call_300");
        bus.ret = 1'b1; step("ret_011");
        chk("ret.pc", 32'(bus.pc_out), 32'h011);

        bus.pc_load = 1'b1; bus.pc_next = 'h005; step("load_005");
        bus.pc_rel = 1'b1; bus.rel_offset = 8'hFA; step("rel_neg_wrap");
        chk("rel_neg.pc", 32'(bus.pc_out), 32'hFFF);
        bus.pc_load = 1'b1; bus.pc_next = 'hFF0; step("load_ff0");
        bus.pc_rel = 1'b1; bus.rel_offset = 8'h7F; step("rel_pos_wrap");
        chk("rel_pos.pc", 32'(bus.pc_out), 32'h06F);

        bus.pc_load = 1'b1; bus.pc_next = 'h100; step("load_100");
        for (int i = 0; i < D + 1; i++) begin
            bus.call = 1'b1; bus.pc_next = bus.pc_out + AW'(1); step("nest_call");
        end
        chk("nest.ovf", 32'(bus.stack_ovf), 32'h1);
        for (int i = 0; i < D + 1; i++) begin
            bus.ret = 1'b1; step("nest_ret");
        end
        chk("nest.unf", 32'(bus.stack_unf), 32'h1);

        bus.err_clr = 1'b1; step("err_clr");
        bus.ret = 1'b1; bus.err_clr = 1'b1; step("err_clr_vs_unf");

        bus.pc_load = 1'b1; bus.call = 1'b1; bus.pc_next = 'h2A0; step("load_beats_call");
        bus.clk_valid = 1'b0; bus.pc_inc = 1'b1; bus.err_clr = 1'b1; step("valid_low");

        for (int i = 0; i < 3; i++) begin
            bus.call = 1'b1; bus.pc_next = AW'('h400 + 16 * i); step("pre_rst_call");
        end
        async_reset_pulse("rst_mid");

        for (int i = 0; i < 600; i++) begin
            bus.clk_valid  = ($urandom_range(0, 7) != 0);
            bus.pc_load    = ($urandom_range(0, 9) == 0);
            bus.call       = ($urandom_range(0, 3) == 0);
            bus.ret        = ($urandom_range(0, 3) == 0);
            bus.pc_rel     = ($urandom_range(0, 3) == 0);
            bus.pc_inc     = ($urandom_range(0, 1) == 0);
            bus.err_clr    = ($urandom_range(0, 15) == 0);
            bus.pc_next    = AW'($urandom);
            bus.rel_offset = OW'($urandom);
            step("rand");
            if (i == 300) async_reset_pulse("rst_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
